// File: rtl/lsu_pkg.sv
// lsu_pkg: shared func3 codes, FSM states and request decode helpers for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_WT, S_RESP} state_t;

   function automatic logic [2:0] size_of(input logic [1:0] f);
      return f == 2'b00 ? 3'd1 : f == 2'b01 ? 3'd2 : 3'd4;
   endfunction

   function automatic logic is_illegal(input logic ld, input logic st, input logic [2:0] f);
      return (ld == st)
         | (ld & !(f inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
         | (st & !(f inside {F3_B, F3_H, F3_W}));
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: load byte extraction/extension and store lane shift/mask generation.
module lsu_lane_align (
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_size,
   input  logic        i_sext,
   input  logic [31:0] i_lo,
   input  logic [31:0] i_hi,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_ldata,
   output logic [63:0] o_wdata,
   output logic [7:0]  o_mask
);

   logic [31:0] w_sh;
   logic        w_sb;

   assign w_sh    = 32'({i_hi, i_lo} >> {i_off, 3'b000});
   assign w_sb    = i_sext & (i_size == 3'd1 ? w_sh[7] : w_sh[15]);
   assign o_ldata = i_size == 3'd1 ? {{24{w_sb}}, w_sh[7:0]}
                  : i_size == 3'd2 ? {{16{w_sb}}, w_sh[15:0]} : w_sh;
   assign o_wdata = {32'b0, i_wdata} << {i_off, 3'b000};
   assign o_mask  = ((8'd1 << i_size) - 8'd1) << i_off;

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: splits pipeline loads/stores into word-aligned memory beats.
// Define LSU_MISALIGN_TRAP_EN to report word-crossing accesses as errors instead of splitting.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_load,
   input  logic              req_store,
   input  logic [2:0]        req_func3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   state_t            r_state, w_next;
   logic              r_load, r_sext, r_split, r_err;
   logic [1:0]        r_off;
   logic [2:0]        r_size;
   logic [ADDR_W-1:0] r_word;
   logic [31:0]       r_wdata, r_lo, r_hi;
   logic              r_resp_valid, r_resp_err;
   logic [31:0]       r_resp_rdata;
   logic              w_acc, w_split, w_err, w_beat, w_hi_beat;
   logic [2:0]        w_size;
   logic [31:0]       w_ldata;
   logic [63:0]       w_wd;
   logic [7:0]        w_mask;

   assign req_ready = r_state == S_IDLE;
   assign w_acc     = req_valid & req_ready;
   assign w_size    = size_of(req_func3[1:0]);
   assign w_split   = ({2'b0, req_addr[1:0]} + {1'b0, w_size}) > 4'd4;
`ifdef LSU_MISALIGN_TRAP_EN
   assign w_err     = is_illegal(req_load, req_store, req_func3) | w_split;
`else
   assign w_err     = is_illegal(req_load, req_store, req_func3);
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_acc ? (w_err ? S_RESP : S_B0) : S_IDLE;
         S_B0:    w_next = r_split ? S_B1 : (r_load ? S_WT : S_RESP);
         S_B1:    w_next = r_load ? S_WT : S_RESP;
         S_WT:    w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // beat0 data arrives while in B1 for split loads, otherwise while in WT
   always_ff @(posedge clk) begin
      if (rst) begin
         r_load       <= 1'b0;
         r_sext       <= 1'b0;
         r_split      <= 1'b0;
         r_err        <= 1'b0;
         r_off        <= 2'b0;
         r_size       <= 3'b0;
         r_word       <= '0;
         r_wdata      <= '0;
         r_lo         <= '0;
         r_hi         <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         if (w_acc) begin
            r_load  <= req_load;
            r_sext  <= ~req_func3[2];
            r_split <= w_split;
            r_err   <= w_err;
            r_off   <= req_addr[1:0];
            r_size  <= w_size;
            r_word  <= {req_addr[ADDR_W-1:2], 2'b00};
            r_wdata <= req_wdata;
         end
         if (r_state == S_B1 && r_load) r_lo <= mem_rdata;
         if (r_state == S_WT && r_split) r_hi <= mem_rdata;
         if (r_state == S_WT && !r_split) r_lo <= mem_rdata;
         r_resp_valid <= r_state == S_RESP;
         r_resp_err   <= r_state == S_RESP && r_err;
         r_resp_rdata <= (r_state == S_RESP && !r_err && r_load) ? w_ldata : 32'b0;
      end
   end

   lsu_lane_align u_align (
      .i_off   (r_off),
      .i_size  (r_size),
      .i_sext  (r_sext),
      .i_lo    (r_lo),
      .i_hi    (r_hi),
      .i_wdata (r_wdata),
      .o_ldata (w_ldata),
      .o_wdata (w_wd),
      .o_mask  (w_mask)
   );

   assign w_beat     = r_state == S_B0 || r_state == S_B1;
   assign w_hi_beat  = r_state == S_B1;
   assign mem_read   = w_beat & r_load;
   assign mem_write  = w_beat & ~r_load;
   assign mem_addr   = w_beat ? (w_hi_beat ? r_word + ADDR_W'(4) : r_word) : '0;
   assign mem_be     = mem_write ? (w_hi_beat ? w_mask[7:4] : w_mask[3:0]) : 4'b0;
   assign mem_wdata  = mem_write ? (w_hi_beat ? w_wd[63:32] : w_wd[31:0]) : 32'b0;
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign resp_rdata = r_resp_rdata;

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- CPU-side load/store initiator that drives the byte-addressed data memory port. It is the requester end of the MemRead/MemWrite/func3 interface.
- Takes one load or store per request from the pipeline and converts it into word-aligned memory beats with byte enables. A misaligned access is split into two beats.
- Load data is aligned and sign-/zero-extended per func3. A single-cycle response pulse is returned.
- Sits between the EX/MEM stage and the data memory, and stalls the pipeline through req_ready.

Parameters:
- ADDR_W, 8, byte-address width. The memory holds 2^ADDR_W bytes and addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; the request is accepted when req_valid & req_ready
- req_load  in  1  load request
- req_store  in  1  store request
- req_func3  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; illegal request
- mem_read  out  1  read beat strobe
- mem_write  out  1  write beat strobe
- mem_addr  out  ADDR_W  word-aligned address; low 2 bits always 0
- mem_be  out  4  byte enables for a write beat
- mem_wdata  out  32  lane-positioned write data
- mem_rdata  in  32  read word; valid the cycle after the mem_read beat

Behaviour:
- Reset: state=IDLE. req_ready=1. All other outputs are 0. Reset in any state aborts the access at the next edge: no further beats are issued and any pending response is dropped.
- FSM states: IDLE, B0, B1, WT, RESP. All outputs are registered or decoded from registers only.
- Request latching: on accept, the request fields are latched. off = addr[1:0]; size = 1/2/4 bytes from func3[1:0]; split = (off + size > 4).
- Illegal requests: load and store both set, neither set, load func3 in {011,110,111}, or store func3 > 010. These go to RESP with resp_err=1 and issue no memory beats.
- B0: drive a beat at {addr[ADDR_W-1:2], 2'b00}. Next state is B1 if split, else WT for a load, else RESP for a store.
- B1: drive a beat at the B0 word address + 4, wrapping modulo 2^ADDR_W. For a load, capture mem_rdata (beat0) into the low word buffer. Next state is WT for a load, RESP for a store.
- WT (loads only): capture mem_rdata into the high buffer if split, else into the low buffer. Next state is RESP.
- RESP: resp_valid=1 for exactly one cycle. Next state is IDLE.
- Load alignment: form {hi, lo}, shift right by 8*off, take the low size bytes, then sign-extend (func3[2]=0) or zero-extend (func3[2]=1).
- Store positioning: form 64-bit data = req_wdata << 8*off and 8-bit mask = ((1<<size)-1) << off. Beat0 uses the low halves; beat1 uses the high halves.
- Read beats assert mem_be=0000.
- Latency from the accept edge to resp_valid:
  - aligned load: 3 cycles
  - split load: 4 cycles
  - aligned store: 2 cycles
  - split store: 3 cycles
  - error: 1 cycle
- Requests presented while not in IDLE are ignored, since req_ready=0.

Optional Feature:
- LSU_MISALIGN_TRAP_EN:
  - Defined: any access with split=1 is treated as illegal, giving resp_err=1 one cycle after accept, with no beats.
  - Undefined: misaligned accesses are split into two beats as described above.

Decomposition:
- Shared package lsu_pkg holds:
  - func3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - the state enum
  - the size-decode function
- One combinational sub-module, lsu_lane_align, performs the load extract/extend and the store shift/mask generation.
- The FSM stays in lsu_mem_master.

Test Plan:
- Memory preloaded with bytes 200..203 = 11 00 00 00 (hex). lw addr 200 → one read beat at mem_addr=200, resp_valid at accept+3 with resp_rdata=0x00000011 and resp_err=0.
- Byte 217 = 0xAA. lb addr 217 → 0xFFFFFFAA. lbu addr 217 → 0x000000AA. Each shows a single beat at mem_addr=216.
- Bytes 215=0x01 and 216=0x60. lh addr 215 → read beats at 212 then 216, resp_rdata=0x00006001 at accept+4. With LSU_MISALIGN_TRAP_EN defined: resp_err=1 at accept+1 and no beats.
- sw 0xDEADBEEF at addr 202 → beat0 mem_addr=200, be=1100, wdata=0xBEEF0000; beat1 mem_addr=204, be=0011, wdata=0x0000DEAD; resp at accept+3. Wrap check: lw addr 254 with ADDR_W=8 → beats at 252 then 0.
- Illegal request (load with func3=011, or sh with req_load=req_store=1) → resp_valid with resp_err=1 at accept+1, mem_read=mem_write=0 throughout.
- rst asserted in B1 of a split load → IDLE next edge, no further beat, no resp_valid, req_ready=1. The next lw addr 204 completes normally with resp_rdata=0x00000009.
